// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch set-associative cache:
// default geometry, controller state encoding and the tag-entry view.
package ifu_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_LINE_WIDTH = 128;
  localparam int DEF_NUM_WAYS   = 4;
  localparam int DEF_NUM_SETS   = 8;

  // Tag entries carry a fixed-width tag field; narrower tags are zero-extended.
  localparam int TAG_MAX_WIDTH  = 64;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    MISS_REQ  = 3'd2,
    MISS_WAIT = 3'd3,
    FLUSH     = 3'd4
  } ifuState_t;

  typedef struct packed {
    logic                     valid;
    logic [TAG_MAX_WIDTH-1:0] tag;
  } tagEntry_t;

endpackage

// File: rtl/ifu_plru_tree.sv
// Combinational tree-PLRU: walks the per-set tree to find the victim way and
// computes the tree after an access to accessWay.
module ifu_plru_tree
  import ifu_pkg::*;
#(
  parameter int NUM_WAYS = DEF_NUM_WAYS,
  localparam int WAY_WIDTH = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0]  treeBits,
  input  logic [WAY_WIDTH-1:0] accessWay,
  output logic [WAY_WIDTH-1:0] victimWay,
  output logic [NUM_WAYS-2:0]  newTreeBits
);

  // Victim walk: a 0 bit steers toward the lower-index child.
  always_comb begin
    int                   node;
    logic                 bitSel;
    logic [WAY_WIDTH-1:0] way;
    node   = 0;
    bitSel = 1'b0;
    way    = '0;
    for (int lvl = 0; lvl < WAY_WIDTH; lvl++) begin
      for (int n = 0; n < NUM_WAYS - 1; n++) begin
        bitSel = (n == node) ? treeBits[n] : bitSel;
      end
      way  = WAY_WIDTH'({way, bitSel});
      node = 2 * node + 1 + int'(bitSel);
    end
    victimWay = way;
  end

  // Access update: every node on the path points away from the accessed way.
  always_comb begin
    int   node;
    logic dir;
    node        = 0;
    dir         = 1'b0;
    newTreeBits = treeBits;
    for (int lvl = 0; lvl < WAY_WIDTH; lvl++) begin
      dir = accessWay[WAY_WIDTH-1-lvl];
      for (int n = 0; n < NUM_WAYS - 1; n++) begin
        newTreeBits[n] = (n == node) ? ~dir : newTreeBits[n];
      end
      node = 2 * node + 1 + int'(dir);
    end
  end

endmodule

// File: rtl/ifu_set_assoc_cache.sv
// Blocking instruction cache: one outstanding fetch, tree-PLRU replacement,
// single-line refill from memory and a set-by-set invalidate-all walk.
module ifu_set_assoc_cache
  import ifu_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int NUM_WAYS   = DEF_NUM_WAYS,
  parameter int NUM_SETS   = DEF_NUM_SETS
) (
  input  logic                                         Clock,
  input  logic                                         Rst,
  input  logic                                         cpu_req_valid,
  output logic                                         cpu_req_ready,
  input  logic [ADDR_WIDTH-1:0]                        cpu_req_addr,
  output logic                                         cpu_rsp_valid,
  output logic [ADDR_WIDTH-1:0]                        cpu_rsp_addr,
  output logic [LINE_WIDTH-1:0]                        cpu_rsp_line,
  output logic                                         mem_req_valid,
  input  logic                                         mem_req_ready,
  output logic [ADDR_WIDTH-$clog2(LINE_WIDTH/8)-1:0]   mem_req_laddr,
  input  logic                                         mem_rsp_valid,
  input  logic [LINE_WIDTH-1:0]                        mem_rsp_line,
  input  logic                                         flush,
  output logic                                         busy,
  output logic [31:0]                                  hit_cnt,
  output logic [31:0]                                  miss_cnt
);

  localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8);
  localparam int SET_WIDTH    = $clog2(NUM_SETS);
  localparam int TAG_WIDTH    = ADDR_WIDTH - SET_WIDTH - OFFSET_WIDTH;
  localparam int LADDR_WIDTH  = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int WAY_WIDTH    = $clog2(NUM_WAYS);

  ifuState_t state;
  ifuState_t nextState;

  logic [ADDR_WIDTH-1:0] reqAddr;
  logic                  flushPending;
  logic [SET_WIDTH-1:0]  flushIdx;

  logic [NUM_WAYS-1:0]   validBits [NUM_SETS];
  logic [NUM_WAYS-2:0]   plruBits  [NUM_SETS];
  logic [TAG_WIDTH-1:0]  tagArray  [NUM_SETS][NUM_WAYS];
  logic [LINE_WIDTH-1:0] dataArray [NUM_SETS][NUM_WAYS];

  logic [SET_WIDTH-1:0]     reqSet;
  logic [TAG_WIDTH-1:0]     reqTag;
  logic [TAG_MAX_WIDTH-1:0] reqTagExt;
  tagEntry_t                entries [NUM_WAYS];

  logic                 hit;
  logic [WAY_WIDTH-1:0] hitWay;
  logic                 hasInvalid;
  logic [WAY_WIDTH-1:0] invalidWay;
  logic [WAY_WIDTH-1:0] plruVictim;
  logic [WAY_WIDTH-1:0] victimWay;
  logic [WAY_WIDTH-1:0] accessWay;
  logic [NUM_WAYS-2:0]  newTree;
  logic                 flushReq;
  logic                 accept;

  assign reqSet    = reqAddr[OFFSET_WIDTH +: SET_WIDTH];
  assign reqTag    = reqAddr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign reqTagExt = TAG_MAX_WIDTH'(reqTag);
  assign flushReq  = flushPending | flush;
  assign accept    = cpu_req_valid & cpu_req_ready;
  assign victimWay = hasInvalid ? invalidWay : plruVictim;
  assign accessWay = (state == LOOKUP) ? hitWay : victimWay;

  // Tag-entry view of the indexed set.
  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      entries[w].valid = validBits[reqSet][w];
      entries[w].tag   = TAG_MAX_WIDTH'(tagArray[reqSet][w]);
    end
  end

  // Hit detection and lowest-index invalid way; descending scan keeps the lowest match.
  always_comb begin
    hit        = 1'b0;
    hitWay     = '0;
    hasInvalid = 1'b0;
    invalidWay = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      hit        = (entries[w].valid && (entries[w].tag == reqTagExt)) ? 1'b1 : hit;
      hitWay     = (entries[w].valid && (entries[w].tag == reqTagExt)) ? WAY_WIDTH'(w) : hitWay;
      hasInvalid = (!entries[w].valid) ? 1'b1 : hasInvalid;
      invalidWay = (!entries[w].valid) ? WAY_WIDTH'(w) : invalidWay;
    end
  end

  ifu_plru_tree #(
    .NUM_WAYS (NUM_WAYS)
  ) plruTree (
    .treeBits    (plruBits[reqSet]),
    .accessWay   (accessWay),
    .victimWay   (plruVictim),
    .newTreeBits (newTree)
  );

  // State register.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; a pending flush is only taken from IDLE, so misses finish first.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (flushReq) begin
          nextState = FLUSH;
        end else if (cpu_req_valid) begin
          nextState = LOOKUP;
        end else begin
          nextState = IDLE;
        end
      end
      LOOKUP: begin
        if (!hit) begin
          nextState = MISS_REQ;
        end else if (accept) begin
          nextState = LOOKUP;
        end else begin
          nextState = IDLE;
        end
      end
      MISS_REQ: begin
        if (mem_req_ready) begin
          nextState = MISS_WAIT;
        end else begin
          nextState = MISS_REQ;
        end
      end
      MISS_WAIT: begin
        if (mem_rsp_valid) begin
          nextState = IDLE;
        end else begin
          nextState = MISS_WAIT;
        end
      end
      FLUSH: begin
        if (flushIdx == SET_WIDTH'(NUM_SETS - 1)) begin
          nextState = IDLE;
        end else begin
          nextState = FLUSH;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Handshake outputs; ready drops whenever a flush is about to be taken.
  always_comb begin
    cpu_req_ready = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE:    cpu_req_ready = ~flushReq;
      LOOKUP:  cpu_req_ready = hit & ~flushReq;
      default: cpu_req_ready = 1'b0;
    endcase
  end

  // Request/response datapath, counters and flush bookkeeping.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      reqAddr       <= '0;
      flushPending  <= 1'b0;
      flushIdx      <= '0;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_addr  <= '0;
      cpu_rsp_line  <= '0;
      mem_req_valid <= 1'b0;
      mem_req_laddr <= '0;
      hit_cnt       <= 32'd0;
      miss_cnt      <= 32'd0;
    end else begin
      cpu_rsp_valid <= 1'b0;
      if ((state == IDLE) && (nextState == FLUSH)) begin
        flushPending <= 1'b0;
      end else if (flush) begin
        flushPending <= 1'b1;
      end
      if (accept) begin
        reqAddr <= cpu_req_addr;
      end
      case (state)
        LOOKUP: begin
          if (hit) begin
            cpu_rsp_valid <= 1'b1;
            cpu_rsp_addr  <= reqAddr;
            cpu_rsp_line  <= dataArray[reqSet][hitWay];
            hit_cnt       <= hit_cnt + 32'd1;
          end else begin
            miss_cnt      <= miss_cnt + 32'd1;
            mem_req_valid <= 1'b1;
            mem_req_laddr <= reqAddr[ADDR_WIDTH-1:OFFSET_WIDTH];
          end
        end
        MISS_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
          end
        end
        MISS_WAIT: begin
          if (mem_rsp_valid) begin
            cpu_rsp_valid <= 1'b1;
            cpu_rsp_addr  <= reqAddr;
            cpu_rsp_line  <= mem_rsp_line;
          end
        end
        FLUSH: flushIdx <= flushIdx + SET_WIDTH'(1);
        default: ;
      endcase
    end
  end

  // Valid and PLRU state: flush walk, hit touch, refill install.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        validBits[s] <= '0;
        plruBits[s]  <= '0;
      end
    end else begin
      if (state == FLUSH) begin
        validBits[flushIdx] <= '0;
        plruBits[flushIdx]  <= '0;
      end else if ((state == LOOKUP) && hit) begin
        plruBits[reqSet] <= newTree;
      end else if ((state == MISS_WAIT) && mem_rsp_valid) begin
        validBits[reqSet][victimWay] <= 1'b1;
        plruBits[reqSet]             <= newTree;
      end
    end
  end

  // Tag and data storage is deliberately left without reset.
  always_ff @(posedge Clock) begin
    if ((state == MISS_WAIT) && mem_rsp_valid) begin
      tagArray[reqSet][victimWay]  <= reqTag;
      dataArray[reqSet][victimWay] <= mem_rsp_line;
    end
  end

  logic unusedLaddrWidth;
  assign unusedLaddrWidth = (LADDR_WIDTH == 0);

endmodule

// File: doc/ifu_set_assoc_cache.md
IFU_SET_ASSOC_CACHE -- requirements
Module: ifu_set_assoc_cache

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter LINE_WIDTH, default 128, line width in bits; must be a power of 2 and at least 32.
REQ-003 SHALL have parameter NUM_WAYS, default 4, associativity; must be a power of 2 and at least 2.
REQ-004 SHALL have parameter NUM_SETS, default 8, set count; must be a power of 2 and at least 2.
REQ-005 SHALL derive the following widths:
- OFFSET_WIDTH = log2(LINE_WIDTH/8).
- SET_WIDTH = log2(NUM_SETS).
- TAG_WIDTH = ADDR_WIDTH-SET_WIDTH-OFFSET_WIDTH.
- LADDR_WIDTH = ADDR_WIDTH-OFFSET_WIDTH.
REQ-006 SHALL have the following ports:
- Clock  in  1  clock.
- Rst  in  1  reset, asynchronous, active-high.
- cpu_req_valid  in  1  fetch request.
- cpu_req_ready  out  1  request accepted when valid&&ready.
- cpu_req_addr  in  ADDR_WIDTH  fetch byte address.
- cpu_rsp_valid  out  1  one-cycle response pulse; there is no backpressure.
- cpu_rsp_addr  out  ADDR_WIDTH  address of the accepted request.
- cpu_rsp_line  out  LINE_WIDTH  instruction line.
- mem_req_valid  out  1  refill request.
- mem_req_ready  in  1  memory accepts the refill request.
- mem_req_laddr  out  LADDR_WIDTH  line address (addr>>OFFSET_WIDTH).
- mem_rsp_valid  in  1  refill data valid.
- mem_rsp_line  in  LINE_WIDTH  refill data.
- flush  in  1  invalidate-all request (pulse).
- busy  out  1  high in any state other than IDLE.
- hit_cnt  out  32  hit counter.
- miss_cnt  out  32  miss counter.

Function
REQ-007 SHALL implement an FSM with states IDLE, LOOKUP, MISS_REQ, MISS_WAIT and FLUSH.
REQ-008 SHALL assert cpu_req_ready in IDLE, and in LOOKUP only when the current lookup hits and no flush is pending.
REQ-009 SHALL, on accept, register the address and move to LOOKUP the next cycle.
REQ-010 SHALL, in LOOKUP, compare the tag against all NUM_WAYS valid entries of the indexed set (address bits [OFFSET_WIDTH+:SET_WIDTH]).
REQ-011 SHALL, on a hit, drive registered cpu_rsp_valid/addr/line in the cycle after LOOKUP, so hit latency is 2 cycles from accept.
- Back-to-back hits sustain one response per cycle.
- On a hit, hit_cnt increments and the set PLRU is updated.
REQ-012 SHALL, on a miss, increment miss_cnt and enter MISS_REQ.
- mem_req_valid and mem_req_laddr are held stable until mem_req_ready.
- The FSM then enters MISS_WAIT.
REQ-013 SHALL, in MISS_WAIT on mem_rsp_valid, write mem_rsp_line into the victim way, set its tag and valid bit, and update the PLRU.
- cpu_rsp is pulsed the next cycle with mem_rsp_line.
- The FSM returns to IDLE.
REQ-014 SHALL select the victim as the lowest-index invalid way if one exists, otherwise the tree-PLRU way.
REQ-015 SHALL hold NUM_WAYS-1 tree-PLRU bits per set.
- Node i has children 2i+1 and 2i+2.
- Bit 0 means the victim lies on the left (lower-index) side.
- On access, each node on the path is set to point away from the accessed way.
REQ-016 SHALL ignore mem_rsp_valid in every state except MISS_WAIT.
REQ-017 SHALL latch a flush pulse in any state as pending.
- Flush is served from IDLE, with priority over cpu_req_valid.
- FLUSH clears one set's valid bits and PLRU per cycle, walking sets 0..NUM_SETS-1, which takes NUM_SETS cycles.
- After the walk the FSM returns to IDLE.
REQ-018 SHALL complete an in-flight miss, including its refill write and response, before a pending flush executes.
REQ-019 SHALL wrap hit_cnt and miss_cnt modulo 2^32.

Reset
REQ-020 SHALL, while Rst is asserted, asynchronously set:
- state to IDLE;
- all valid bits, PLRU bits, counters, the pending-flush flag and all outputs to 0, except cpu_req_ready, which is 1 after reset deassertion.
REQ-021 SHALL leave data and tag arrays unreset; an in-flight miss is abandoned with mem_req_valid at 0.

Structure
REQ-022 SHALL take default parameters, the state enum and the tag-entry typedef (valid, tag) from ifu_pkg.
REQ-023 SHALL instantiate a combinational sub-module ifu_plru_tree (parameter NUM_WAYS) that computes the victim way and the updated tree bits.

Verification
All scenarios use default parameters.
REQ-024 SHALL cover cold miss then hit:
- Cold miss at 0x0000_1000 -> mem_req_laddr 0x0000100; refill line 0xA5..A5 -> cpu_rsp_line 0xA5..A5; miss_cnt=1.
- Re-request -> response 2 cycles after accept; hit_cnt=1.
REQ-025 SHALL cover set-0 eviction:
- Fill 0x000, 0x080, 0x100, 0x180 (ways 0-3), then request 0x200 -> evicts way 0.
- 0x080 then hits; 0x000 then misses.
REQ-026 SHALL cover back-to-back hits: 4 hitting requests in consecutive cycles -> 4 consecutive cpu_rsp_valid cycles.
REQ-027 SHALL cover memory stalls:
- mem_req_ready low 10 cycles -> mem_req_valid and mem_req_laddr stable throughout.
- mem_rsp_valid pulsed in IDLE -> ignored, arrays unchanged.
REQ-028 SHALL cover flush during a miss: flush pulsed in MISS_WAIT -> refill response completes, then busy high 8 cycles; 0x1000 then misses.
REQ-029 SHALL cover reset mid-miss: Rst asserted in MISS_WAIT -> mem_req_valid=0 immediately and counters 0; the next lookup misses.
